// File: rtl/tri_pwm_dt.sv
// tri_pwm_dt: triangle-carrier PWM with double-buffered duty, complementary gates and dead-time insertion.
// Optional fault input and sticky fault latch are built when TRI_PWM_FAULT_EN is defined.
module tri_pwm_dt #(
    parameter int DT_W = 8
) (
    input  logic            clk_100M,
    input  logic            phase_rst,
    input  logic [15:0]     tri_u,
    input  logic [15:0]     duty,
    input  logic            duty_load,
    input  logic [DT_W-1:0] dead_time,
`ifdef TRI_PWM_FAULT_EN
    input  logic            fault_n,
    output logic            fault_lat,
`endif
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            valley,
    output logic [15:0]     duty_act
);

    typedef enum logic [1:0] {OFF, DEAD, HIGH, LOW} state_t;

    state_t          state;
    logic            tgt;
    logic [DT_W-1:0] cnt;
    logic [15:0]     tri_q, tri_prev, pend;
    logic            dir, dir_d, pend_v, req_h, valley_ev;

    assign valley_ev = dir & ~dir_d;

    // Carrier pipeline: slope tracking, valley pulse and the duty compare.
    always_ff @(posedge clk_100M or posedge phase_rst)
        if (phase_rst) begin
            tri_q    <= '0;
            tri_prev <= '0;
            dir      <= 1'b0;
            dir_d    <= 1'b0;
            valley   <= 1'b0;
            req_h    <= 1'b0;
        end else begin
            tri_q    <= tri_u;
            tri_prev <= tri_q;
            dir      <= (tri_q > tri_prev) ? 1'b1 : (tri_q < tri_prev) ? 1'b0 : dir;
            dir_d    <= dir;
            valley   <= valley_ev;
            req_h    <= tri_q < duty_act;
        end

    // Duty double buffer: pending word moves to the active word at a carrier valley.
    always_ff @(posedge clk_100M or posedge phase_rst)
        if (phase_rst) begin
            duty_act <= '0;
            pend     <= '0;
            pend_v   <= 1'b0;
        end else if (valley_ev && duty_load) begin
            duty_act <= duty;
            pend_v   <= 1'b0;
        end else if (valley_ev && pend_v) begin
            duty_act <= pend;
            pend_v   <= 1'b0;
        end else if (duty_load) begin
            pend     <= duty;
            pend_v   <= 1'b1;
        end

`ifdef TRI_PWM_FAULT_EN
    // Sticky fault latch: set by a low fault_n at any time, cleared only by phase_rst.
    always_ff @(posedge clk_100M or posedge phase_rst or negedge fault_n)
        if (phase_rst)
            fault_lat <= 1'b0;
        else if (!fault_n)
            fault_lat <= 1'b1;
`endif

    // Gate FSM: every side change passes through DEAD for dead_time+1 cycles with both gates low.
`ifdef TRI_PWM_FAULT_EN
    always_ff @(posedge clk_100M or posedge phase_rst or negedge fault_n)
`else
    always_ff @(posedge clk_100M or posedge phase_rst)
`endif
        if (phase_rst) begin
            state <= OFF;
            tgt   <= 1'b0;
            cnt   <= '0;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end
`ifdef TRI_PWM_FAULT_EN
        else if (!fault_n || fault_lat) begin
            state <= OFF;
            pwm_h <= 1'b0;
            pwm_l <= 1'b0;
        end
`endif
        else begin
            case (state)
                OFF: begin
                    state <= DEAD;
                    tgt   <= req_h;
                    cnt   <= dead_time;
                    pwm_h <= 1'b0;
                    pwm_l <= 1'b0;
                end
                DEAD: begin
                    if (req_h != tgt) begin
                        tgt <= req_h;
                        cnt <= dead_time;
                    end else if (cnt == '0) begin
                        state <= tgt ? HIGH : LOW;
                        pwm_h <= tgt;
                        pwm_l <= ~tgt;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HIGH: begin
                    if (!req_h) begin
                        state <= DEAD;
                        tgt   <= 1'b0;
                        cnt   <= dead_time;
                        pwm_h <= 1'b0;
                    end
                end
                LOW: begin
                    if (req_h) begin
                        state <= DEAD;
                        tgt   <= 1'b1;
                        cnt   <= dead_time;
                        pwm_l <= 1'b0;
                    end
                end
            endcase
        end

endmodule

// File: doc/tri_pwm_dt.md
# tri_pwm_dt

Triangle-carrier PWM stage with complementary outputs and dead-time insertion. Consumes the unsigned triangle from the DDS triangle generator (tri_u), compares it against a double-buffered duty word, and drives a high-side/low-side gate pair. It shares the DDS phase reset, so carrier and PWM restart together.

## Interface
- DT_W, 8, width of dead_time and of the dead-time counter
- clk_100M  in  1  system clock, 100 MHz
- phase_rst  in  1  reset, asynchronous, active-high; the same strobe that zeroes the DDS phase
- tri_u  in  16  unsigned triangle carrier sample, new value every cycle
- duty  in  16  duty compare word
- duty_load  in  1  one-cycle strobe; captures duty into the pending register
- dead_time  in  DT_W  dead time in clk_100M cycles, sampled when each dead interval starts
- pwm_h  out  1  high-side gate, registered
- pwm_l  out  1  low-side gate, registered
- valley  out  1  one-cycle pulse at each carrier minimum, registered
- duty_act  out  16  duty value currently in use, registered

## Operation
- Stage 1: tri_q <= tri_u; tri_prev <= tri_q.
- Slope flag dir: 1 if tri_q > tri_prev, 0 if tri_q < tri_prev, held if equal.
- Valley event: dir changes 0 -> 1. Peak events are not used.
- Duty buffering: duty_load=1 writes duty into pend and sets pend_v. On a valley event with pend_v=1, duty_act <= pend and pend_v clears. If duty_load and a valley event coincide, duty_act takes the duty input directly and pend_v clears. Multiple loads between valleys: last one wins.
- Stage 2: req_h <= (tri_q < duty_act), unsigned. duty_act=0 gives constant low. duty_act=0xFFFF gives high except when tri_q=0xFFFF.
- Output FSM: OFF, DEAD, HIGH, LOW. tgt holds the side being switched to. cnt is DT_W wide.
  - OFF: both outputs low. Next cycle goes to DEAD with tgt=req_h and cnt=dead_time.
  - DEAD: both outputs low. If req_h != tgt: tgt <= req_h and cnt <= dead_time (restart). Else if cnt==0: go to HIGH if tgt=1, otherwise LOW. Else cnt decrements.
  - HIGH: pwm_h=1. If req_h=0: go to DEAD, tgt=0, cnt=dead_time.
  - LOW: pwm_l=1. If req_h=1: go to DEAD, tgt=1, cnt=dead_time.
- pwm_h and pwm_l are never both 1, in any state or cycle.
- dead_time=0: DEAD lasts exactly 1 cycle with both outputs low. There is no zero-gap switch.

## Timing
- Reset values: pwm_h=0, pwm_l=0, valley=0, duty_act=0, pend=0, pend_v=0, dir=0, state=OFF, cnt=0, tri_q=0, tri_prev=0.
- Assertion mid-operation forces both gates low asynchronously, within the same cycle.
- Latency: tri_u sampled at edge n -> req_h valid after edge n+1 -> FSM state/outputs update at edge n+2.
- A req_h change at edge k produces: both low from edge k+1 through edge k+1+dead_time; the new side goes high at edge k+2+dead_time. The gap is dead_time+1 cycles.
- valley asserts one cycle after the dir transition is registered. The new duty_act is visible to the compare on the following cycle.
- First edge after phase_rst release: OFF -> DEAD. The first gate turns on no earlier than edge dead_time+2.

## Configuration
- TRI_PWM_FAULT_EN defined: adds input fault_n (1 bit, active-low, async).
  - A low level on fault_n clears pwm_h and pwm_l combinationally at the output register, and sets a sticky latch.
  - While the latch is set, the FSM is held in OFF.
  - The latch clears only on phase_rst. Adds output fault_lat (1 bit, reset 0).
- Not defined: there is no fault_n port and no fault_lat port, and the FSM never enters a forced-OFF state after reset.

## Test plan
- Reset check: hold phase_rst with random inputs -> pwm_h=pwm_l=valley=0 and duty_act=0. Assert phase_rst while pwm_h=1 -> pwm_h=0 in the same cycle.
- Steady compare: triangle of period 512 (0 -> 0xFF00 in 256 steps and back), duty loaded 0x8000, dead_time=10. Required after the first valley:
  - pwm_h high ~50% of each period;
  - every transition shows 11 cycles with both outputs low;
  - never both high.
- Double buffering: load 0x4000 mid-period, then load 0xC000 before the valley -> duty_act changes once, to 0xC000, exactly at the valley cycle. Load coincident with valley -> takes effect at that valley.
- Extremes:
  - duty 0 -> pwm_l continuously high, pwm_h never high.
  - duty 0xFFFF with carrier peak 0xFF00 -> pwm_h continuously high.
  - dead_time=0 -> exactly a 1-cycle gap at every transition.
- Dead-time glitch: req_h toggles 1 -> 0 -> 1 within a dead window with dead_time=20 -> counter restarts, neither output pulses, and the target side turns on 21 cycles after the last toggle is registered.
- Fault (with TRI_PWM_FAULT_EN): pulse fault_n low for 1 cycle while pwm_h=1 -> both outputs low and fault_lat=1 until phase_rst; after release, the normal OFF -> DEAD start-up sequence follows.
